restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: active-low synchronous load; while low, operands are (re)loaded; while high, division iterates.
REQ-004 SHALL have port dividend, input, 4 bits: unsigned dividend, sampled only while start is low.
REQ-005 SHALL have port divisor, input, 4 bits: unsigned divisor, sampled only while start is low.
REQ-006 SHALL have port quotient, output, 4 bits: quotient register Q, continuously driven.
REQ-007 SHALL have port remainder, output, 4 bits: low 4 bits of partial-remainder register A, continuously driven.
REQ-008 SHALL have port count, output reg, 2 bits: iteration counter.
REQ-009 SHALL have port done, output reg, 1 bit: result valid.
REQ-010 SHALL have port div_zero, output reg, 1 bit: the loaded divisor was zero.

Function
REQ-011 SHALL hold internal registers A (5 bits, signed partial remainder), Q (4 bits), and M (4 bits, divisor), plus a state register with states IDLE, RUN, and DONE.
REQ-012 SHALL, on a rising edge with start low, load A=0, Q=dividend, M=divisor, count=0, done=0, div_zero=(divisor==0), state=RUN, regardless of the current state.
REQ-013 SHALL, on each rising edge in RUN with start high, perform one restoring step:
- shift {A,Q} left by 1;
- T = A - {1'b0,M}, formed as A + ~{1'b0,M} + 1 in 5 bits;
- if T[4]==1: keep the shifted A and set Q[0]=0;
- else: A=T and set Q[0]=1;
- count = count + 1.
REQ-014 SHALL leave RUN for DONE on the step taken with count==3, set done=1 on that edge, and let count wrap to 0.
REQ-015 SHALL hold A, Q, M, count, done, and div_zero unchanged in IDLE and DONE while start is high.
REQ-016 SHALL have a latency of exactly 4 rising edges with start high, counted after the last load edge, until done=1.
REQ-017 SHALL, after done, present quotient = floor(dividend/divisor) and remainder = dividend mod divisor for every divisor != 0.
REQ-018 SHALL, for divisor==0, run the normal 4 steps without special-casing and finish with quotient=4'hF, remainder=dividend, div_zero=1, done=1.
REQ-019 SHALL treat start low during RUN or DONE as an abort: operands are reloaded and the division restarts per REQ-012.
REQ-020 SHALL NOT let dividend or divisor changes while start is high affect the computation in progress.
REQ-021 SHALL keep quotient and remainder driven combinationally from Q and A[3:0]; intermediate values are visible during RUN and carry no validity guarantee before done.

Reset
REQ-022 SHALL, while reset is low, asynchronously force A=0, Q=0, M=0, count=0, done=0, div_zero=0, state=IDLE; reset has priority over start.
REQ-023 SHALL remain in IDLE after reset is released until start is sampled low.
REQ-024 SHALL abandon any operation in progress when reset is asserted mid-operation, with no partial result retained.

Verification
REQ-025 SHALL pass: load 13/4, release start -> after 4 edges done=1, quotient=3, remainder=1, div_zero=0, count=0.
REQ-026 SHALL pass: load 15/1 -> quotient=15, remainder=0; load 7/9 -> quotient=0, remainder=7; each with done on the 4th edge.
REQ-027 SHALL pass: load 9/0 -> after 4 edges quotient=4'hF, remainder=9, div_zero=1, done=1.
REQ-028 SHALL pass: load 13/4, run 2 edges, assert reset asynchronously between edges -> all outputs 0 immediately, state=IDLE; after release, outputs hold at 0 with start high.
REQ-029 SHALL pass: load 13/4, run 2 edges, pull start low with 14/3 for 1 edge, release -> done=0 through the restart, then after 4 edges quotient=4, remainder=2.
REQ-030 SHALL pass: after done, change dividend/divisor with start high for 3 edges -> outputs and done unchanged.

Source files
------------

// File: rtl/restoring_divider_if.sv
// restoring_divider_if: operand load/start handshake and result bus for the restoring divider.
interface restoring_divider_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic [1:0] count;
  logic       done;
  logic       div_zero;
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, count, done, div_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, count, done, div_zero
  );
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider: 4-bit unsigned restoring divider, one quotient bit per clock.
module restoring_divider (
  input logic                clk,
  input logic                reset,
  restoring_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state, state_nx;
  logic       load, step;
  logic [4:0] a, a_sh, t;
  logic [3:0] q, m, q_nx;
  logic [8:0] sh;
  logic [1:0] cnt;
  logic       done_r, dz;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = !bus.start ? RUN :
               (state == RUN && cnt == 2'd3) ? DONE : state;
  always_comb begin
    load = !bus.start;
    step = bus.start && state == RUN;
  end
  assign sh   = {a, q} << 1;
  assign a_sh = sh[8:4];
  // t[4] set means the trial subtraction went negative, so A is restored
  assign t    = a_sh + ~{1'b0, m} + 5'd1;
  assign q_nx = sh[3:0] | {3'b000, ~t[4]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a      <= '0;
      q      <= '0;
      m      <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
      dz     <= 1'b0;
    end else if (load) begin
      a      <= '0;
      q      <= bus.dividend;
      m      <= bus.divisor;
      cnt    <= '0;
      done_r <= 1'b0;
      dz     <= bus.divisor == 4'd0;
    end else if (step) begin
      a      <= t[4] ? a_sh : t;
      q      <= q_nx;
      cnt    <= cnt + 2'd1;
      done_r <= cnt == 2'd3;
    end
  assign bus.quotient  = q;
  assign bus.remainder = a[3:0];
  assign bus.count     = cnt;
  assign bus.done      = done_r;
  assign bus.div_zero  = dz;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: randomized and directed scoreboard bench for restoring_divider.
module tb_restoring_divider;
  logic clk = 1'b0;
  logic reset = 1'b0;
  restoring_divider_if bus ();
  restoring_divider dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic done_prev = 1'b0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input int x, input int y);
    exp_t e;
    if (y == 0) begin
      e.q = 4'hF; e.r = 4'(x); e.dz = 1'b1;
    end else begin
      e.q = 4'(x / y); e.r = 4'(x % y); e.dz = 1'b0;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_zero", bus.div_zero, e.dz);
      end
    end
    done_prev <= bus.done;
  end
  task automatic start_op(input int x, input int y, input bit push);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = 4'(x);
    bus.divisor = 4'(y);
    if (push) sb.push_back(model(x, y));
    @(negedge clk);
    chk("load_done", bus.done, 0);
    chk("load_count", bus.count, 0);
    bus.start = 1'b1;
    bus.dividend = 4'($urandom);
    bus.divisor = 4'($urandom);
  endtask
  task automatic run_check();
    repeat (3) @(negedge clk);
    chk("early_done", bus.done, 0);
    @(negedge clk);
    chk("done_latency", bus.done, 1);
    chk("count_wrap", bus.count, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_quotient"}, bus.quotient, 0);
    chk({tag, "_remainder"}, bus.remainder, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_div_zero"}, bus.div_zero, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b1;
    bus.dividend = 4'd11;
    bus.divisor = 4'd5;
    #3 chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("idle_hold");
    start_op(13, 4, 1); run_check();
    start_op(15, 1, 1); run_check();
    start_op(7, 9, 1);  run_check();
    start_op(9, 0, 1);  run_check();
    repeat (3) begin
      @(negedge clk);
      bus.dividend = 4'($urandom);
      bus.divisor = 4'($urandom);
    end
    chk("hold_quotient", bus.quotient, 15);
    chk("hold_remainder", bus.remainder, 9);
    chk("hold_done", bus.done, 1);
    chk("hold_div_zero", bus.div_zero, 1);
    start_op(13, 4, 0);
    repeat (2) @(negedge clk);
    start_op(14, 3, 1); run_check();
    start_op(13, 4, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("post_reset");
    for (int i = 0; i < 40; i++) begin
      start_op($urandom_range(0, 15), $urandom_range(0, 15), 1);
      run_check();
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
